// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and filter-mode encoding for the display path.
package vga_timing_pkg;

  // Default 640x480@60 timing, counted in pixel clocks / lines.
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_SYNC_POL  = 1'b0;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Raster counters are 10 bits wide, so totals above this cannot be represented.
  localparam int MAX_TOTAL = 1023;

  typedef enum logic [2:0] {
    FILT_PASS   = 3'b000,
    FILT_MOSAIC = 3'b001,
    FILT_RSVD2  = 3'b010,
    FILT_RSVD3  = 3'b011,
    FILT_RSVD4  = 3'b100
  } filt_mode_e;

  // True when a parameter set fits the divider and the 10-bit counters.
  function automatic bit timing_legal(input int clk_div, input int h_total, input int v_total);
    return (clk_div >= 1) && (clk_div <= 16) &&
           (h_total <= MAX_TOTAL) && (v_total <= MAX_TOTAL);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate enable, h/v counters, registered sync/DE
// decode, line/frame pulses and a frame-synchronous filter-mode shadow register.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] filter_sel_req,
  input  logic       filter_sel_upd,
  output logic       pclk_en,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start,
  output logic [2:0] filter_sel,
  output logic       filter_sel_pending
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] TICK_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Refuse to elaborate with a divider or totals the counters cannot hold.
  generate
    if (!timing_legal(CLK_DIV, H_TOTAL, V_TOTAL)) begin : g_bad_params
      $error("vga_timing_gen: CLK_DIV must be 1..16 and H/V totals must not exceed 1023");
    end
  endgenerate

  logic [3:0] tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       frame_wrap;
  logic [2:0] sel_q;
  logic [2:0] pend_val;
  logic       pend_q;

  // Pixel enable comes straight from the divider state and is held off in reset.
  assign pclk_en    = (tick == TICK_LAST) && !reset;
  assign h_wrap     = pclk_en && (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);

  assign x_pixel            = h_cnt;
  assign y_pixel            = v_cnt;
  assign filter_sel         = sel_q;
  assign filter_sel_pending = pend_q;

  // Pixel divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values of the others, independent of block order.
    if (reset) begin
      tick <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + 4'd1;
    end
  end

  // Next raster position; decoded outputs are registered from it so they line up with the counters.
  always_comb begin
    // NOTE: every signal gets a default before the conditional logic so no
    // path leaves it unassigned, which would infer a latch.
    h_next = h_cnt;
    v_next = v_cnt;
    if (pclk_en) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  // Raster counters plus registered DE, sync and line/frame pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      DE          <= 1'b0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      DE          <= (h_next < H_VIS) && (v_next < V_VIS);
      h_sync      <= ((h_next >= HS_BEG) && (h_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      v_sync      <= ((v_next >= VS_BEG) && (v_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
    end
  end

  // Filter-mode shadow: requests wait for the wrap into (0,0) so a frame never mixes modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= FILT_PASS;
      pend_val <= FILT_PASS;
      pend_q   <= 1'b0;
    end else if (frame_wrap) begin
      // A strobe coinciding with the boundary is newer than anything pending.
      if (filter_sel_upd) begin
        sel_q <= filter_sel_req;
      end else if (pend_q) begin
        sel_q <= pend_val;
      end
      pend_q <= 1'b0;
    end else if (filter_sel_upd) begin
      pend_val <= filter_sel_req;
      pend_q   <= 1'b1;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the VGA raster that drives the display path: pixel-rate enable, h_sync/v_sync, DE and the raw x_pixel/y_pixel counters that the image-filter stage consumes.
Also owns a frame-synchronous shadow register for the filter mode, so filter_sel changes only at a frame boundary and a frame is never filtered with mixed modes.
Sits between the system clock domain and the frame-buffer read, filter and VGA output stages.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal 1..16
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  system clock; the block's only clock
reset  in  1  synchronous, active-high reset
filter_sel_req  in  3  requested filter mode (000 pass, 001 mosaic, others reserved)
filter_sel_upd  in  1  one-clk strobe that captures filter_sel_req
pclk_en  out  1  pixel-rate enable
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
DE  out  1  display enable (visible region)
x_pixel  out  10  raw horizontal count, 0..H_TOTAL-1
y_pixel  out  10  raw vertical count, 0..V_TOTAL-1
line_start  out  1  one-clk pulse when x_pixel becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
filter_sel  out  3  frame-stable filter mode
filter_sel_pending  out  1  a captured request is waiting for the next frame boundary

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Reset values (while reset = 1):
  - tick = 0; h_cnt = v_cnt = 0; x_pixel = y_pixel = 0.
  - pclk_en = DE = line_start = frame_start = 0.
  - h_sync = v_sync = ~SYNC_POL (inactive).
  - filter_sel = 000; pending value = 000; filter_sel_pending = 0.
- Divider:
  - tick counts 0..CLK_DIV-1 and wraps.
  - pclk_en = (tick == CLK_DIV-1), decoded from the tick register and forced 0 during reset.
  - With CLK_DIV = 1, pclk_en is constantly 1 after reset.
- Counters advance only on an edge where pclk_en = 1:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - On that same wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- Outputs are registered and cycle-aligned with x_pixel/y_pixel, which equal h_cnt/v_cnt:
  - DE = (x < H_VISIBLE) && (y < V_VISIBLE).
  - h_sync is active for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - v_sync is active for y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
  - First clk after reset release: x = y = 0 and DE = 1.
- Pulses:
  - line_start is high for exactly one clk, the clk after the edge where h_cnt wraps to 0.
  - frame_start is high for exactly one clk, the clk after the edge where both counters wrap to 0.
  - Neither pulse fires on reset release.
- Filter-mode handshake:
  - filter_sel_upd = 1 captures filter_sel_req into the pending register and sets filter_sel_pending. Multiple strobes in one frame: the last one wins.
  - On the wrap edge into (0,0), if pending: filter_sel <= pending value and filter_sel_pending <= 0.
  - filter_sel_upd on the wrap edge itself: filter_sel_req goes directly to filter_sel and filter_sel_pending <= 0.
  - filter_sel never changes at any other edge.
- Reset mid-frame: abandon the frame and restart at (0,0) on release. Any pending request is discarded.
- Arithmetic: all comparisons unsigned and 10-bit. Parameters whose totals exceed 1023 are illegal; an elaboration-time check flags them.
- Frame period = H_TOTAL x V_TOTAL x CLK_DIV clks = 1,680,000 at the defaults.

Decomposition:
- vga_timing_pkg holds:
  - default timing constants and the derived H_TOTAL / V_TOTAL;
  - the filter mode enum: FILT_PASS = 3'b000, FILT_MOSAIC = 3'b001, FILT_RSVD2..FILT_RSVD4.
- No sub-module. Divider, h/v counters, sync decode and mode shadow register fit in one module of about 150 lines.

Test Plan:
1. Reset for 3 clks, run 2 frames at defaults -> pclk_en on every 4th clk; x steps 0..799; exactly 640 DE pclks per line on lines 0..479; DE = 0 on lines 480..524.
2. Sync check -> h_sync low for exactly 96 pclks (x = 656..751) every line; v_sync low for exactly lines 490..491 (1600 pclks); both high elsewhere.
3. Count pulses over 2 frames -> 1050 line_start and 2 frame_start pulses; consecutive frame_start pulses exactly 1,680,000 clks apart; none at reset release.
4. Mode update:
   - filter_sel_upd with req = 001 at (100,200) -> filter_sel_pending = 1 and filter_sel = 000 until the wrap; filter_sel = 001 and pending = 0 in the frame_start clk.
   - Second case: upd req = 001 then req = 010 in the same frame -> filter_sel = 010 at the boundary.
5. filter_sel_upd with req = 001 on the exact wrap edge -> filter_sel = 001 in the next clk; pending stays 0.
6. Pending req = 001, then reset pulsed at (400,300) -> next clk all outputs at reset values; after release x = y = 0, DE = 1, filter_sel = 000, no frame_start.
